// File: rtl/ysyx_25040129_mdu_seq_pkg.sv
// Shared types for the multi-cycle M-extension sequencer: op/state encodings and widths.
// Optional feature macro used by the sequencer: YSYX_25040129_MDU_SINGLE_CYCLE_MUL_EN.
package ysyx_25040129_mdu_seq_pkg;

    localparam int MDU_XLEN   = 32;
    localparam int MDU_REG_AW = 5;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic op_is_mul(input logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_src1_signed(input logic [2:0] op);
        case (mdu_op_e'(op))
            MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

    function automatic logic op_src2_signed(input logic [2:0] op);
        case (mdu_op_e'(op))
            MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25040129_mdu_seq_core.sv
// MDU datapath: magnitude capture, shift-add / restoring-divide step, sign fixup, special results.
// With YSYX_25040129_MDU_SINGLE_CYCLE_MUL_EN the multiply is done combinationally at start.
module ysyx_25040129_mdu_seq_core
    import ysyx_25040129_mdu_seq_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_step,
    input  logic            i_finish,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    output logic            o_fast,
    output logic [XLEN-1:0] o_result
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;
    logic [2:0]        r_op;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_result;

    logic              w_s1, w_s2;
    logic [XLEN-1:0]   w_a, w_b;
    logic              w_special;
    logic [XLEN-1:0]   w_fast_res;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_try;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_acc_step;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_final;
`ifdef YSYX_25040129_MDU_SINGLE_CYCLE_MUL_EN
    logic [2*XLEN-1:0] w_fmul;
`endif

    // Operand magnitudes; the most negative value maps onto 2^(XLEN-1), which still fits unsigned.
    always_comb begin
        w_s1 = op_src1_signed(i_op) & i_src1[XLEN-1];
        w_s2 = op_src2_signed(i_op) & i_src2[XLEN-1];
        w_a  = w_s1 ? (~i_src1 + 1'b1) : i_src1;
        w_b  = w_s2 ? (~i_src2 + 1'b1) : i_src2;
        w_special = ~op_is_mul(i_op) &
                    ((i_src2 == '0) ||
                     (op_src1_signed(i_op) && i_src1 == {1'b1, {(XLEN-1){1'b0}}} && i_src2 == '1));
    end

    always_comb begin
        o_fast = w_special;
        if (i_src2 == '0) w_fast_res = op_is_rem(i_op) ? i_src1 : '1;
        else              w_fast_res = op_is_rem(i_op) ? '0 : i_src1;
`ifdef YSYX_25040129_MDU_SINGLE_CYCLE_MUL_EN
        w_fmul = {{XLEN{1'b0}}, w_a} * {{XLEN{1'b0}}, w_b};
        if (w_s1 ^ w_s2) w_fmul = ~w_fmul + 1'b1;
        if (op_is_mul(i_op)) begin
            o_fast     = 1'b1;
            w_fast_res = (i_op == MDU_MUL) ? w_fmul[XLEN-1:0] : w_fmul[2*XLEN-1:XLEN];
        end
`endif
    end

    // One iteration: upper half is the running partial product / remainder.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_div_try  = r_acc[2*XLEN-1:XLEN-1];
        w_div_diff = w_div_try - {1'b0, r_b};
        if (op_is_mul(r_op))
            w_acc_step = {w_mul_sum, r_acc[XLEN-1:1]};
        else if (w_div_diff[XLEN])
            w_acc_step = {w_div_try[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        else
            w_acc_step = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end

    always_comb begin
        w_prod_fix = r_neg_q ? (~w_acc_step + 1'b1) : w_acc_step;
        if (op_is_mul(r_op))
            w_final = (r_op == MDU_MUL) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
        else if (op_is_rem(r_op))
            w_final = r_neg_r ? (~w_acc_step[2*XLEN-1:XLEN] + 1'b1) : w_acc_step[2*XLEN-1:XLEN];
        else
            w_final = r_neg_q ? (~w_acc_step[XLEN-1:0] + 1'b1) : w_acc_step[XLEN-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (i_start) begin
            r_op    <= i_op;
            r_acc   <= {{XLEN{1'b0}}, w_a};
            r_b     <= w_b;
            r_neg_q <= w_s1 ^ w_s2;
            r_neg_r <= w_s1;
            if (o_fast) r_result <= w_fast_res;
        end else if (i_step) begin
            r_acc <= w_acc_step;
            if (i_finish) r_result <= w_final;
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/ysyx_25040129_mdu_seq.sv
// Multi-cycle MUL/DIV sequencer between IDU and LSU: IDLE/BUSY/DONE FSM around the MDU core.
// Optional YSYX_25040129_MDU_SINGLE_CYCLE_MUL_EN makes MUL* complete one cycle after accept.
module ysyx_25040129_mdu_seq
    import ysyx_25040129_mdu_seq_pkg::*;
#(
    parameter int XLEN   = MDU_XLEN,
    parameter int REG_AW = MDU_REG_AW
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [2:0]        i_in_op,
    input  logic [XLEN-1:0]   i_in_src1,
    input  logic [XLEN-1:0]   i_in_src2,
    input  logic [REG_AW-1:0] i_in_rd,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [XLEN-1:0]   o_out_result,
    output logic [REG_AW-1:0] o_out_rd,
    output logic [REG_AW-1:0] o_busy_rd,
    output logic              o_busy
);

    localparam int CW = $clog2(XLEN);

    mdu_state_e        r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [REG_AW-1:0] r_rd;
    logic              w_accept, w_fast, w_step, w_finish;
    logic [XLEN-1:0]   w_result;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = w_fast ? ST_DONE : ST_BUSY;
            ST_BUSY: if (r_cnt == CW'(XLEN-1)) w_next = ST_DONE;
            ST_DONE: if (i_out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (i_flush) w_next = ST_IDLE;
    end

    always_comb begin
        o_in_ready   = (r_state == ST_IDLE);
        o_out_valid  = (r_state == ST_DONE);
        o_busy       = (r_state != ST_IDLE);
        o_busy_rd    = o_busy ? r_rd : '0;
        o_out_rd     = o_out_valid ? r_rd : '0;
        o_out_result = o_out_valid ? w_result : '0;
        w_accept     = i_in_valid & o_in_ready & ~i_flush;
        w_step       = (r_state == ST_BUSY) & ~i_flush;
        w_finish     = w_step & (r_cnt == CW'(XLEN-1));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_rd  <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_rd  <= i_in_rd;
        end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    ysyx_25040129_mdu_seq_core #(.XLEN(XLEN)) u_core (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (w_accept),
        .i_step   (w_step),
        .i_finish (w_finish),
        .i_op     (i_in_op),
        .i_src1   (i_in_src1),
        .i_src2   (i_in_src2),
        .o_fast   (w_fast),
        .o_result (w_result)
    );

endmodule

// File: tb/tb_ysyx_25040129_mdu_seq.sv
// Scoreboard bench for the MDU sequencer: directed ops push expected results, a monitor pops on handshake.
module tb_ysyx_25040129_mdu_seq;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
`ifdef YSYX_25040129_MDU_SINGLE_CYCLE_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [31:0] in_src1 = '0;
    logic [31:0] in_src2 = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [4:0]  busy_rd;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    ysyx_25040129_mdu_seq dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_op      (in_op),
        .i_in_src1    (in_src1),
        .i_in_src2    (in_src2),
        .i_in_rd      (in_rd),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_result (out_result),
        .o_out_rd     (out_rd),
        .o_busy_rd    (busy_rd),
        .o_busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every accepted result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got result 0x%08h rd %0d, expected no output", out_result, out_rd);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_result"}, out_result, mon_e.res);
                check({mon_e.name, "_rd"}, {27'd0, out_rd}, {27'd0, mon_e.rd});
            end
        end
    end

    task automatic wait_ready(input string name);
        for (int i = 0; i < 100 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL %s_ready_timeout: in_ready got 0, expected 1 within 100 cycles", name);
        end
    endtask

    // Drive one request for exactly one accept edge; optionally expect a result.
    task automatic send(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input bit expect_out,
                        input logic [31:0] exp);
        exp_t e;
        wait_ready(name);
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_rd = rd;
        if (expect_out) begin
            e.name = name; e.res = exp; e.rd = rd;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op = 3'($urandom); in_src1 = $urandom; in_src2 = $urandom; in_rd = 5'($urandom);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_lat);
        int lat;
        send(name, op, a, b, rd, 1'b1, exp);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_busy_rd", {27'd0, busy_rd}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul_7_m3",    OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, MUL_LAT);
        run_op("mulhu_ff",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, MUL_LAT);
        run_op("mulh_m1",     OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, MUL_LAT);
        run_op("mulhsu_m1_2", OP_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, MUL_LAT);
        run_op("mulh_min",    OP_MULH,   32'h80000000, 32'h80000000, 5'd5,  32'h40000000, MUL_LAT);
        run_op("mul_low0",    OP_MUL,    32'h00010000, 32'h00010000, 5'd17, 32'h00000000, MUL_LAT);
        run_op("div_m7_2",    OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, DIV_LAT);
        run_op("rem_m7_2",    OP_REM,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, DIV_LAT);
        run_op("div_7_m2",    OP_DIV,    32'd7,        32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD, DIV_LAT);
        run_op("rem_7_m2",    OP_REM,    32'd7,        32'hFFFFFFFE, 5'd16, 32'd1,        DIV_LAT);
        run_op("divu_100_0",  OP_DIVU,   32'd100,      32'd0,        5'd8,  32'hFFFFFFFF, 1);
        run_op("rem_5_0",     OP_REM,    32'd5,        32'd0,        5'd9,  32'd5,        1);
        run_op("div_ovf",     OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1);
        run_op("rem_ovf",     OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,        1);
        run_op("remu_100_7",  OP_REMU,   32'd100,      32'd7,        5'd12, 32'd2,        DIV_LAT);
        run_op("divu_max_1",  OP_DIVU,   32'hFFFFFFFF, 32'd1,        5'd14, 32'hFFFFFFFF, DIV_LAT);

        // Backpressure: result held for 5 cycles with out_ready low.
        out_ready = 1'b0;
        run_op("bp_mul", OP_MUL, 32'h00012345, 32'h10, 5'd13, 32'h00123450, MUL_LAT);
        for (int i = 0; i < 5; i++) begin
            check("bp_result", out_result, 32'h00123450);
            check("bp_rd", {27'd0, out_rd}, 32'd13);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_busy_rd", {27'd0, busy_rd}, 32'd13);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_after", {31'd0, busy}, 32'd0);

        // Flush in BUSY at cnt=10: op is dropped without a result.
        send("flush_op", OP_DIVU, 32'd1000, 32'd3, 5'd20, 1'b0, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= out_valid;
            @(posedge clk); #1;
        end
        check("flush_no_valid", {31'd0, seen}, 32'd0);
        run_op("after_flush", OP_DIVU, 32'd1000, 32'd3, 5'd21, 32'd333, DIV_LAT);

        // Reset mid-op at cnt=20.
        send("reset_op", OP_REMU, 32'd12345, 32'd100, 5'd22, 1'b0, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_busy_rd", {27'd0, busy_rd}, 32'd0);
        check("mrst_out_rd", {27'd0, out_rd}, 32'd0);
        check("mrst_out_result", out_result, 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= out_valid;
            @(posedge clk); #1;
        end
        check("mrst_no_valid", {31'd0, seen}, 32'd0);
        run_op("divu_9_4", OP_DIVU, 32'd9, 32'd4, 5'd23, 32'd2, DIV_LAT);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
